// File: rtl/tetris_ctrl_gen2.sv
// Tetris game sequencer: spawn, move, gravity, drops, hold, lock and scoring.
// Every candidate position goes through the collision-probe handshake before it commits.
module tetris_ctrl_gen2 #(
    parameter int unsigned BOARD_W         = 10,
    parameter int unsigned X_W             = 4,
    parameter int unsigned Y_W             = 5,
    parameter int unsigned BASE_INTERVAL   = 25000000,
    parameter int unsigned INTERVAL_STEP   = 2000000,
    parameter int unsigned MIN_INTERVAL    = 2500000,
    parameter int unsigned LINES_PER_LEVEL = 10,
    parameter int unsigned MAX_LEVEL       = 15,
    parameter logic [7:0]  LFSR_SEED       = 8'hAA
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    input  logic [2:0]     cmd,
    output logic           cmd_ready,
    output logic           probe_valid,
    output logic [X_W-1:0] probe_x,
    output logic [Y_W-1:0] probe_y,
    output logic [2:0]     probe_piece,
    output logic [1:0]     probe_rot,
    input  logic           probe_ack,
    input  logic           probe_hit,
    output logic           place_piece,
    input  logic           clear_done,
    input  logic [2:0]     clear_lines,
    output logic [X_W-1:0] cur_x,
    output logic [Y_W-1:0] cur_y,
    output logic [2:0]     cur_piece,
    output logic [1:0]     cur_rot,
    output logic [2:0]     next_piece,
    output logic [2:0]     hold_piece,
    output logic           hold_valid,
    output logic [19:0]    score,
    output logic [3:0]     level,
    output logic [15:0]    lines_total,
    output logic           game_over
);

    typedef enum logic [2:0] {
        StSpawn, StSpawnChk, StIdle, StProbe, StLock, StClearWait, StOver
    } state_t;

    typedef enum logic [2:0] {OpLeft, OpRight, OpDown, OpRot, OpDrop, OpGrav} op_t;

    localparam logic [X_W-1:0] SpawnX   = X_W'(BOARD_W / 2 - 1);
    localparam logic [2:0]     CmdLeft  = 3'd0;
    localparam logic [2:0]     CmdRight = 3'd1;
    localparam logic [2:0]     CmdDown  = 3'd2;
    localparam logic [2:0]     CmdRot   = 3'd3;
    localparam logic [2:0]     CmdDrop  = 3'd4;
    localparam logic [2:0]     CmdHold  = 3'd5;

    state_t      state_q, state_d;
    op_t         op_q;
    logic [7:0]  lfsr_q;
    logic        hold_used_q, swap_q;
    logic [31:0] grav_cnt_q, lvl_prod, interval;
    logic [7:0]  lil_q, lil_sum;
    logic        grav_due, probe_done, cmd_fire, is_fall;
    logic [2:0]  draw, lines_cl;
    logic [9:0]  clear_pts;
    logic [4:0]  lvl_p1;
    logic [19:0] score_add, score_next;
    logic [20:0] score_sum;
    logic [16:0] lines_sum;

    // Gravity period shrinks with level but never drops below the floor.
    always_comb begin
        lvl_prod = 32'(level) * INTERVAL_STEP;
        if (lvl_prod + MIN_INTERVAL >= BASE_INTERVAL) interval = MIN_INTERVAL;
        else                                          interval = BASE_INTERVAL - lvl_prod;
    end

    assign grav_due   = (grav_cnt_q >= interval - 32'd1);
    assign probe_done = probe_valid && probe_ack;
    assign is_fall    = (op_q == OpDown) || (op_q == OpGrav) || (op_q == OpDrop);
    assign lines_cl   = (clear_lines > 3'd4) ? 3'd4 : clear_lines;
    assign lvl_p1     = {1'b0, level} + 5'd1;
    assign lil_sum    = lil_q + 8'(lines_cl);
    assign lines_sum  = {1'b0, lines_total} + 17'(lines_cl);
    assign score_sum  = {1'b0, score} + {1'b0, score_add};
    assign score_next = score_sum[20] ? 20'hFFFFF : score_sum[19:0];

    always_comb begin
        draw = lfsr_q[2:0];
        if (draw == 3'd7) draw = lfsr_q[5:3];
        if (draw == 3'd7) draw = 3'd0;
    end

    always_comb begin
        case (lines_cl)
            3'd0:    clear_pts = 10'd0;
            3'd1:    clear_pts = 10'd100;
            3'd2:    clear_pts = 10'd300;
            3'd3:    clear_pts = 10'd500;
            default: clear_pts = 10'd800;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        cmd_fire    = 1'b0;
        place_piece = 1'b0;
        score_add   = '0;
        case (state_q)
            StSpawn:    state_d = StSpawnChk;
            StSpawnChk: if (probe_done) state_d = probe_hit ? StOver : StIdle;
            StIdle: begin
                cmd_ready = !grav_due;
                cmd_fire  = cmd_valid && !grav_due;
                if (grav_due) begin
                    state_d = StProbe;
                end else if (cmd_fire) begin
                    if (cmd <= CmdDrop)                         state_d = StProbe;
                    else if (cmd == CmdHold && !hold_used_q)    state_d = StSpawn;
                end
            end
            StProbe: begin
                if (probe_done) begin
                    if (probe_hit) begin
                        state_d = is_fall ? StLock : StIdle;
                    end else begin
                        state_d = (op_q == OpDrop) ? StProbe : StIdle;
                        if (op_q == OpDown) score_add = 20'd1;
                        if (op_q == OpDrop) score_add = 20'd2;
                    end
                end
            end
            StLock: begin
                place_piece = 1'b1;
                state_d     = StClearWait;
            end
            StClearWait: begin
                if (clear_done) begin
                    score_add = 20'(clear_pts) * 20'(lvl_p1);
                    state_d   = StSpawn;
                end
            end
            StOver:  cmd_ready = 1'b1;
            default: state_d = StSpawn;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StSpawn;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OpLeft;
            lfsr_q      <= LFSR_SEED;
            hold_used_q <= 1'b0;
            swap_q      <= 1'b0;
            grav_cnt_q  <= '0;
            lil_q       <= '0;
            probe_valid <= 1'b0;
            probe_x     <= '0;
            probe_y     <= '0;
            probe_piece <= '0;
            probe_rot   <= '0;
            cur_x       <= SpawnX;
            cur_y       <= '0;
            cur_piece   <= '0;
            cur_rot     <= '0;
            next_piece  <= '0;
            hold_piece  <= '0;
            hold_valid  <= 1'b0;
            score       <= '0;
            level       <= '0;
            lines_total <= '0;
            game_over   <= 1'b0;
        end else begin
            score <= score_next;
            if (!grav_due) grav_cnt_q <= grav_cnt_q + 32'd1;
            case (state_q)
                StSpawn: begin
                    cur_x       <= SpawnX;
                    cur_y       <= '0;
                    cur_rot     <= '0;
                    probe_x     <= SpawnX;
                    probe_y     <= '0;
                    probe_rot   <= '0;
                    probe_valid <= 1'b1;
                    swap_q      <= 1'b0;
                    // A hold swap already loaded cur_piece and must not consume a draw.
                    if (swap_q) begin
                        probe_piece <= cur_piece;
                    end else begin
                        probe_piece <= next_piece;
                        cur_piece   <= next_piece;
                        next_piece  <= draw;
                        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                    end
                end
                StSpawnChk: begin
                    grav_cnt_q <= '0;
                    if (probe_done) begin
                        probe_valid <= 1'b0;
                        if (probe_hit) game_over <= 1'b1;
                    end
                end
                StIdle: begin
                    probe_x     <= cur_x;
                    probe_y     <= cur_y;
                    probe_piece <= cur_piece;
                    probe_rot   <= cur_rot;
                    if (grav_due) begin
                        probe_y     <= cur_y + Y_W'(1);
                        op_q        <= OpGrav;
                        probe_valid <= 1'b1;
                    end else if (cmd_fire) begin
                        probe_valid <= (cmd <= CmdDrop);
                        case (cmd)
                            CmdLeft: begin
                                probe_x <= cur_x - X_W'(1);
                                op_q    <= OpLeft;
                            end
                            CmdRight: begin
                                probe_x <= cur_x + X_W'(1);
                                op_q    <= OpRight;
                            end
                            CmdDown: begin
                                probe_y <= cur_y + Y_W'(1);
                                op_q    <= OpDown;
                            end
                            CmdRot: begin
                                probe_rot <= cur_rot + 2'd1;
                                op_q      <= OpRot;
                            end
                            CmdDrop: begin
                                probe_y <= cur_y + Y_W'(1);
                                op_q    <= OpDrop;
                            end
                            CmdHold: begin
                                if (!hold_used_q) begin
                                    hold_used_q <= 1'b1;
                                    hold_piece  <= cur_piece;
                                    if (hold_valid) begin
                                        cur_piece <= hold_piece;
                                        swap_q    <= 1'b1;
                                    end else begin
                                        hold_valid <= 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StProbe: begin
                    // Only a hard drop lingers here with probe_valid low: re-arm the next row.
                    if (!probe_valid) begin
                        probe_valid <= 1'b1;
                    end else if (probe_ack) begin
                        probe_valid <= 1'b0;
                        if (!probe_hit) begin
                            cur_x   <= probe_x;
                            cur_y   <= probe_y;
                            cur_rot <= probe_rot;
                            probe_y <= probe_y + Y_W'(1);
                            if (probe_y != cur_y) grav_cnt_q <= '0;
                        end
                    end
                end
                StLock: hold_used_q <= 1'b0;
                StClearWait: begin
                    if (clear_done) begin
                        lines_total <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
                        if (32'(lil_sum) >= LINES_PER_LEVEL) begin
                            lil_q <= lil_sum - 8'(LINES_PER_LEVEL);
                            if (32'(level) < MAX_LEVEL) level <= level + 4'd1;
                        end else begin
                            lil_q <= lil_sum;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_ctrl_gen2.sv
// Directed bench for tetris_ctrl_gen2 with a small board-edge/floor collision model.
module tb_tetris_ctrl_gen2;

    logic        clk = 1'b0;
    logic        rst_n, cmd_valid, cmd_ready, probe_valid, probe_ack, probe_hit;
    logic [2:0]  cmd, probe_piece, cur_piece, next_piece, hold_piece, clear_lines;
    logic [3:0]  probe_x, cur_x, level;
    logic [4:0]  probe_y, cur_y;
    logic [1:0]  probe_rot, cur_rot;
    logic        place_piece, clear_done, hold_valid, game_over;
    logic [19:0] score;
    logic [15:0] lines_total;

    logic        ack_en;
    logic [4:0]  y_limit;
    logic [3:0]  last_px;
    int          n_cmp, n_err, probe_cnt, place_cnt, ready_hi, pc;

    always #5 clk = ~clk;

    assign probe_ack = ack_en;
    assign probe_hit = (probe_x >= 4'd10) || (probe_y >= y_limit);

    tetris_ctrl_gen2 #(
        .BASE_INTERVAL(4000),
        .INTERVAL_STEP(200),
        .MIN_INTERVAL (1000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .cmd_ready  (cmd_ready),
        .probe_valid(probe_valid),
        .probe_x    (probe_x),
        .probe_y    (probe_y),
        .probe_piece(probe_piece),
        .probe_rot  (probe_rot),
        .probe_ack  (probe_ack),
        .probe_hit  (probe_hit),
        .place_piece(place_piece),
        .clear_done (clear_done),
        .clear_lines(clear_lines),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .cur_piece  (cur_piece),
        .cur_rot    (cur_rot),
        .next_piece (next_piece),
        .hold_piece (hold_piece),
        .hold_valid (hold_valid),
        .score      (score),
        .level      (level),
        .lines_total(lines_total),
        .game_over  (game_over)
    );

    always @(posedge clk) begin
        if (probe_valid && probe_ack) begin
            probe_cnt <= probe_cnt + 1;
            last_px   <= probe_x;
        end
        if (place_piece) place_cnt <= place_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) break;
            tick(1);
        end
        check(tag, 32'(cmd_ready), 32'd1);
    endtask

    task automatic send_cmd(input logic [2:0] c);
        wait_ready("cmd_ready");
        cmd_valid = 1'b1;
        cmd       = c;
        tick(1);
        cmd_valid = 1'b0;
        cmd       = 3'd0;
    endtask

    task automatic wait_place(input string tag);
        ready_hi = 0;
        for (int i = 0; i < 200; i++) begin
            if (place_piece) break;
            if (cmd_ready) ready_hi++;
            tick(1);
        end
        check(tag, 32'(place_piece), 32'd1);
    endtask

    task automatic lock_clear(input logic [2:0] lines);
        send_cmd(3'd4);
        wait_place("lock_pulse");
        tick(1);
        clear_lines = lines;
        clear_done  = 1'b1;
        tick(1);
        clear_done  = 1'b0;
        wait_ready("respawn");
    endtask

    initial begin
        n_cmp = 0; n_err = 0; probe_cnt = 0; place_cnt = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; clear_done = 1'b0; clear_lines = 3'd0;
        ack_en = 1'b1; y_limit = 5'd31;
        tick(2);
        check("rst_cur_x", 32'(cur_x), 32'd4);
        check("rst_score", 32'(score), 32'd0);
        check("rst_probe_valid", 32'(probe_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst_n = 1'b1;
        wait_ready("first_idle");
        check("spawn_cur_piece", 32'(cur_piece), 32'd0);
        check("spawn_next_piece", 32'(next_piece), 32'd2);
        check("spawn_xy", {cur_x, 3'd0, cur_y}, {4'd4, 3'd0, 5'd0});

        // Gravity at level 0 fires after 4000 idle cycles.
        tick(3890);
        check("grav_not_yet", 32'(cur_y), 32'd0);
        tick(200);
        check("grav_fell", 32'(cur_y), 32'd1);
        check("grav_no_score", 32'(score), 32'd0);

        repeat (4) begin
            send_cmd(3'd0);
            wait_ready("move_done");
        end
        check("left_to_0", 32'(cur_x), 32'd0);
        send_cmd(3'd0);
        wait_ready("left_hit_done");
        check("left_hit_wrap_probe", 32'(last_px), 32'd15);
        check("left_hit_x", 32'(cur_x), 32'd0);
        check("left_hit_no_place", 32'(place_cnt), 32'd0);
        send_cmd(3'd1);
        wait_ready("right_done");
        check("right_x", 32'(cur_x), 32'd1);
        send_cmd(3'd3);
        wait_ready("rot_done");
        check("rot", 32'(cur_rot), 32'd1);
        send_cmd(3'd2);
        wait_ready("soft_done");
        check("soft_y", 32'(cur_y), 32'd2);
        check("soft_score", 32'(score), 32'd1);

        send_cmd(3'd5);
        wait_ready("hold1_done");
        check("hold1_hold", {hold_valid, hold_piece}, {1'b1, 3'd0});
        check("hold1_cur", 32'(cur_piece), 32'd2);
        check("hold1_next", 32'(next_piece), 32'd5);
        send_cmd(3'd5);
        tick(3);
        check("hold2_ignored_cur", 32'(cur_piece), 32'd2);
        check("hold2_ignored_hold", 32'(hold_piece), 32'd0);
        check("hold2_ignored_y", 32'(cur_y), 32'd0);

        y_limit = 5'd18;
        pc = probe_cnt;
        send_cmd(3'd4);
        wait_place("drop_place");
        check("drop_ready_low", 32'(ready_hi), 32'd0);
        check("drop_probes", 32'(probe_cnt - pc), 32'd18);
        check("drop_y", 32'(cur_y), 32'd17);
        check("drop_score", 32'(score), 32'd35);
        tick(1);
        clear_lines = 3'd0; clear_done = 1'b1;
        tick(1);
        clear_done = 1'b0;
        wait_ready("drop_respawn");
        check("drop_single_pulse", 32'(place_cnt), 32'd1);
        check("piece3_cur", 32'(cur_piece), 32'd5);
        check("piece3_next", 32'(next_piece), 32'd3);

        send_cmd(3'd5);
        wait_ready("swap_done");
        check("swap_cur", 32'(cur_piece), 32'd0);
        check("swap_hold", 32'(hold_piece), 32'd5);
        check("swap_next", 32'(next_piece), 32'd3);

        y_limit = 5'd1;
        lock_clear(3'd4);
        check("clr4_l0", 32'(score), 32'd835);
        lock_clear(3'd4);
        lock_clear(3'd2);
        check("lvl1_score", 32'(score), 32'd1935);
        check("lvl1_level", 32'(level), 32'd1);
        check("lvl1_lines", 32'(lines_total), 32'd10);
        lock_clear(3'd4);
        lock_clear(3'd4);
        lock_clear(3'd2);
        check("lvl2_level", 32'(level), 32'd2);
        check("lvl2_score", 32'(score), 32'd5735);
        lock_clear(3'd4);
        check("tetris_l2", 32'(score), 32'd8135);
        lock_clear(3'd7);
        check("clamp7_score", 32'(score), 32'd10535);
        check("clamp7_lines", 32'(lines_total), 32'd28);

        repeat (40) lock_clear(3'd4);
        check("lvl_sat", 32'(level), 32'd15);
        check("lines_188", 32'(lines_total), 32'd188);
        lock_clear(3'd4);
        check("lvl_stays", 32'(level), 32'd15);
        repeat (90) lock_clear(3'd4);
        check("score_sat", 32'(score), 32'hFFFFF);
        check("lines_552", 32'(lines_total), 32'd552);

        y_limit = 5'd0;
        lock_clear(3'd0);
        check("game_over", 32'(game_over), 32'd1);
        pc = probe_cnt;
        send_cmd(3'd0);
        tick(5);
        check("over_no_probe", 32'(probe_cnt - pc), 32'd0);
        check("over_probe_valid", 32'(probe_valid), 32'd0);

        ack_en = 1'b0; y_limit = 5'd31;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("probe_pending", 32'(probe_valid), 32'd1);
        pc = place_cnt;
        #3 rst_n = 1'b0;
        #1;
        check("async_probe_valid", 32'(probe_valid), 32'd0);
        check("async_state", {game_over, hold_valid, level, cur_x}, {1'b0, 1'b0, 4'd0, 4'd4});
        check("async_score", 32'(score), 32'd0);
        check("async_lines", 32'(lines_total), 32'd0);
        ack_en = 1'b1;
        tick(1);
        rst_n = 1'b1;
        wait_ready("restart_idle");
        check("restart_pieces", {cur_piece, next_piece}, {3'd0, 3'd2});
        check("restart_no_pulse", 32'(place_cnt), 32'(pc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
